// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the user-mode CSR unit.
//   - CSR address map constants
//   - CSR instruction op encodings
//   - ustatus / uip / uie bit positions
//   - interrupt cause codes (low bits of ucause / oIrqCause)
package csr_pkg;

    localparam logic [11:0] CSR_USTATUS  = 12'h000;
    localparam logic [11:0] CSR_FFLAGS   = 12'h001;
    localparam logic [11:0] CSR_FRM      = 12'h002;
    localparam logic [11:0] CSR_FCSR     = 12'h003;
    localparam logic [11:0] CSR_UIE      = 12'h004;
    localparam logic [11:0] CSR_UTVEC    = 12'h005;
    localparam logic [11:0] CSR_USCRATCH = 12'h040;
    localparam logic [11:0] CSR_UEPC     = 12'h041;
    localparam logic [11:0] CSR_UCAUSE   = 12'h042;
    localparam logic [11:0] CSR_UTVAL    = 12'h043;
    localparam logic [11:0] CSR_UIP      = 12'h044;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int unsigned UIE_BIT  = 0;
    localparam int unsigned UPIE_BIT = 4;
    localparam int unsigned USIP_BIT = 0;
    localparam int unsigned UTIP_BIT = 4;
    localparam int unsigned UEIP_BIT = 8;

    localparam logic [3:0] IRQ_CODE_SW    = 4'd0;
    localparam logic [3:0] IRQ_CODE_TIMER = 4'd4;
    localparam logic [3:0] IRQ_CODE_EXT   = 4'd8;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment enable and per-half load.
//   clk, rst (async, active-high) - clock / reset
//   inc_en                        - add one this cycle
//   wr_lo, wr_hi, wr_data         - load low / high 32-bit half
//   count                         - current value; wraps 2^64-1 -> 0
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] count
);

    logic [63:0] cnt_nxt;

    // Full 64-bit add so the low-to-high carry lands in the same cycle.
    always_comb begin
        cnt_nxt = count + 64'(inc_en);
        if (wr_lo) cnt_nxt[31:0]  = wr_data;
        if (wr_hi) cnt_nxt[63:32] = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= cnt_nxt;
    end

endmodule

// File: rtl/csr_unit_u.sv
// csr_unit_u: user-mode CSR unit (RISC-V N extension subset + counters).
//   iCLK, iRST (async, active-high)
//   iCsrValid/iCsrOp/iCsrAddr/iCsrWdata -> oCsrRdata (old value), oCsrIllegal
//   iTrapReq/iTrapPc/iTrapCause/iTrapVal - trap entry; oTrapVector handler target
//   iUretReq - return from trap; oEpc = uepc
//   iInstRet - retire pulse for instret
//   iSwIrq/iTimerIrq/iExtIrq -> oIrqPending, oIrqCause
module csr_unit_u
    import csr_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter bit          FP_EN      = 1'b1,
    parameter bit          CNT_EN     = 1'b1,
    parameter int unsigned TIME_DIV   = 1,
    parameter bit          NEGEDGE_WR = 1'b0
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iCsrValid,
    input  logic [1:0]      iCsrOp,
    input  logic [11:0]     iCsrAddr,
    input  logic [XLEN-1:0] iCsrWdata,
    output logic [XLEN-1:0] oCsrRdata,
    output logic            oCsrIllegal,
    input  logic            iTrapReq,
    input  logic [XLEN-1:0] iTrapPc,
    input  logic [XLEN-1:0] iTrapCause,
    input  logic [XLEN-1:0] iTrapVal,
    input  logic            iUretReq,
    input  logic            iInstRet,
    input  logic            iSwIrq,
    input  logic            iTimerIrq,
    input  logic            iExtIrq,
    output logic [XLEN-1:0] oTrapVector,
    output logic [XLEN-1:0] oEpc,
    output logic            oIrqPending,
    output logic [XLEN-1:0] oIrqCause
);

    localparam int unsigned PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

    // Pipelined cores update CSR state on the falling edge.
    logic clk_st;
    assign clk_st = NEGEDGE_WR ? ~iCLK : iCLK;

    logic            st_uie, st_upie, usip_q;
    logic [2:0]      ie_q;                 // {ext, timer, sw}
    logic [4:0]      fflags_q;
    logic [2:0]      frm_q;
    logic [XLEN-1:0] utvec_q, uscratch_q, uepc_q, ucause_q, utval_q;
    logic [63:0]     cycle_cnt, time_cnt, instret_cnt;
    logic [PW-1:0]   pre_q;
    logic            time_tick;

    logic [2:0]      ip_vec, pend;
    logic [XLEN-1:0] rd_val, rmw_old, wr_val, tv_base;
    logic            impl, wr_intent, illegal, csr_we;
    csr_op_e         op;

    // Place a {ext, timer, sw} triple at bit positions 8/4/0.
    function automatic logic [XLEN-1:0] spread3(input logic [2:0] v);
        spread3           = '0;
        spread3[USIP_BIT] = v[0];
        spread3[UTIP_BIT] = v[1];
        spread3[UEIP_BIT] = v[2];
    endfunction

    assign ip_vec = {iExtIrq, iTimerIrq, usip_q | iSwIrq};
    assign pend   = ie_q & ip_vec;

    // Time prescaler: one tick every TIME_DIV cycles.
    assign time_tick = (pre_q == PW'(TIME_DIV - 1));

    always_ff @(posedge clk_st or posedge iRST) begin
        if (iRST)           pre_q <= '0;
        else if (time_tick) pre_q <= '0;
        else                pre_q <= pre_q + PW'(1);
    end

    csr_counter64 u_cycle (
        .clk(clk_st), .rst(iRST), .inc_en(1'b1), .wr_lo(1'b0), .wr_hi(1'b0),
        .wr_data(32'h0), .count(cycle_cnt)
    );
    csr_counter64 u_time (
        .clk(clk_st), .rst(iRST), .inc_en(time_tick), .wr_lo(1'b0), .wr_hi(1'b0),
        .wr_data(32'h0), .count(time_cnt)
    );
    csr_counter64 u_instret (
        .clk(clk_st), .rst(iRST), .inc_en(iInstRet), .wr_lo(1'b0), .wr_hi(1'b0),
        .wr_data(32'h0), .count(instret_cnt)
    );

    // Read mux and address decode.
    always_comb begin
        rd_val = '0;
        impl   = 1'b0;
        case (iCsrAddr)
            CSR_USTATUS: begin
                impl             = 1'b1;
                rd_val[UIE_BIT]  = st_uie;
                rd_val[UPIE_BIT] = st_upie;
            end
            CSR_FFLAGS:   if (FP_EN) begin impl = 1'b1; rd_val[4:0] = fflags_q; end
            CSR_FRM:      if (FP_EN) begin impl = 1'b1; rd_val[2:0] = frm_q; end
            CSR_FCSR:     if (FP_EN) begin impl = 1'b1; rd_val[7:0] = {frm_q, fflags_q}; end
            CSR_UIE:      begin impl = 1'b1; rd_val = spread3(ie_q); end
            CSR_UTVEC:    begin impl = 1'b1; rd_val = utvec_q; end
            CSR_USCRATCH: begin impl = 1'b1; rd_val = uscratch_q; end
            CSR_UEPC:     begin impl = 1'b1; rd_val = uepc_q; end
            CSR_UCAUSE:   begin impl = 1'b1; rd_val = ucause_q; end
            CSR_UTVAL:    begin impl = 1'b1; rd_val = utval_q; end
            CSR_UIP:      begin impl = 1'b1; rd_val = spread3(ip_vec); end
            CSR_CYCLE:    if (CNT_EN) begin impl = 1'b1; rd_val = XLEN'(cycle_cnt[31:0]); end
            CSR_TIME:     if (CNT_EN) begin impl = 1'b1; rd_val = XLEN'(time_cnt[31:0]); end
            CSR_INSTRET:  if (CNT_EN) begin impl = 1'b1; rd_val = XLEN'(instret_cnt[31:0]); end
            CSR_CYCLEH:   if (CNT_EN) begin impl = 1'b1; rd_val = XLEN'(cycle_cnt[63:32]); end
            CSR_TIMEH:    if (CNT_EN) begin impl = 1'b1; rd_val = XLEN'(time_cnt[63:32]); end
            CSR_INSTRETH: if (CNT_EN) begin impl = 1'b1; rd_val = XLEN'(instret_cnt[63:32]); end
            default: ;
        endcase
    end

    // Write decode. RS/RC with zero wdata do not count as writes, so they
    // are legal on the read-only counter space (0xCxx).
    always_comb begin
        op        = csr_op_e'(iCsrOp);
        wr_intent = (op == CSR_OP_RW) ||
                    (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (|iCsrWdata));
        illegal   = iCsrValid && (!impl || ((iCsrAddr[11:10] == 2'b11) && wr_intent));
        csr_we    = iCsrValid && wr_intent && !illegal && !iTrapReq && !iUretReq;
        // uip RMW must not fold the external sw-irq line into the stored bit.
        rmw_old   = (iCsrAddr == CSR_UIP) ? spread3({2'b00, usip_q}) : rd_val;
        case (op)
            CSR_OP_RW: wr_val = iCsrWdata;
            CSR_OP_RS: wr_val = rmw_old | iCsrWdata;
            CSR_OP_RC: wr_val = rmw_old & ~iCsrWdata;
            default:   wr_val = rmw_old;
        endcase
    end

    always_ff @(posedge clk_st or posedge iRST) begin
        if (iRST) begin
            st_uie     <= 1'b0;
            st_upie    <= 1'b0;
            usip_q     <= 1'b0;
            ie_q       <= '0;
            fflags_q   <= '0;
            frm_q      <= '0;
            utvec_q    <= '0;
            uscratch_q <= '0;
            uepc_q     <= '0;
            ucause_q   <= '0;
            utval_q    <= '0;
        end else if (iTrapReq) begin
            uepc_q   <= iTrapPc & ~XLEN'(1);
            ucause_q <= iTrapCause;
            utval_q  <= iTrapVal;
            st_upie  <= st_uie;
            st_uie   <= 1'b0;
        end else if (iUretReq) begin
            st_uie  <= st_upie;
            st_upie <= 1'b1;
        end else if (csr_we) begin
            case (iCsrAddr)
                CSR_USTATUS: begin
                    st_uie  <= wr_val[UIE_BIT];
                    st_upie <= wr_val[UPIE_BIT];
                end
                CSR_FFLAGS:   fflags_q <= wr_val[4:0];
                CSR_FRM:      frm_q    <= wr_val[2:0];
                CSR_FCSR: begin
                    frm_q    <= wr_val[7:5];
                    fflags_q <= wr_val[4:0];
                end
                CSR_UIE:      ie_q       <= {wr_val[UEIP_BIT], wr_val[UTIP_BIT], wr_val[USIP_BIT]};
                CSR_UTVEC:    utvec_q    <= wr_val & ~XLEN'(2);
                CSR_USCRATCH: uscratch_q <= wr_val;
                CSR_UEPC:     uepc_q     <= wr_val;
                CSR_UCAUSE:   ucause_q   <= wr_val;
                CSR_UTVAL:    utval_q    <= wr_val;
                CSR_UIP:      usip_q     <= wr_val[USIP_BIT];
                default: ;
            endcase
        end
    end

    // Vectored mode only offsets interrupt causes.
    always_comb begin
        tv_base = utvec_q & ~XLEN'(3);
        if (utvec_q[0] && iTrapCause[XLEN-1])
            oTrapVector = tv_base + {iTrapCause[XLEN-3:0], 2'b00};
        else
            oTrapVector = tv_base;
    end

    // Interrupt priority: ext > sw > timer.
    always_comb begin
        oIrqCause = '0;
        if (pend[2]) begin
            oIrqCause[XLEN-1] = 1'b1;
            oIrqCause[3:0]    = IRQ_CODE_EXT;
        end else if (pend[0]) begin
            oIrqCause[XLEN-1] = 1'b1;
            oIrqCause[3:0]    = IRQ_CODE_SW;
        end else if (pend[1]) begin
            oIrqCause[XLEN-1] = 1'b1;
            oIrqCause[3:0]    = IRQ_CODE_TIMER;
        end
    end

    assign oIrqPending = st_uie && (|pend);
    assign oCsrRdata   = rd_val;
    assign oCsrIllegal = illegal;
    assign oEpc        = uepc_q;

endmodule

// File: tb/tb_csr_unit_u.sv
// tb_csr_unit_u: directed self-checking bench for csr_unit_u, plus a
// standalone csr_counter64 to exercise half loads and 64-bit wrap.
module tb_csr_unit_u;

    logic        clk, rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_illegal;
    logic        trap_req, uret_req, inst_ret;
    logic [31:0] trap_pc, trap_cause, trap_val;
    logic        sw_irq, timer_irq, ext_irq;
    logic [31:0] trap_vector, epc, irq_cause;
    logic        irq_pending;

    logic        c_inc, c_wlo, c_whi;
    logic [31:0] c_wd;
    logic [63:0] c_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] rd_last;
    logic        ill_last;
    logic [63:0] mcyc, mc_last;

    csr_unit_u #(.XLEN(32), .FP_EN(1'b1), .CNT_EN(1'b1), .TIME_DIV(3), .NEGEDGE_WR(1'b0)) dut (
        .iCLK(clk), .iRST(rst),
        .iCsrValid(csr_valid), .iCsrOp(csr_op), .iCsrAddr(csr_addr), .iCsrWdata(csr_wdata),
        .oCsrRdata(csr_rdata), .oCsrIllegal(csr_illegal),
        .iTrapReq(trap_req), .iTrapPc(trap_pc), .iTrapCause(trap_cause), .iTrapVal(trap_val),
        .iUretReq(uret_req), .iInstRet(inst_ret),
        .iSwIrq(sw_irq), .iTimerIrq(timer_irq), .iExtIrq(ext_irq),
        .oTrapVector(trap_vector), .oEpc(epc),
        .oIrqPending(irq_pending), .oIrqCause(irq_cause)
    );

    csr_counter64 u_cnt (
        .clk(clk), .rst(rst), .inc_en(c_inc), .wr_lo(c_wlo), .wr_hi(c_whi),
        .wr_data(c_wd), .count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: one per rising edge out of reset.
    always @(posedge clk or posedge rst) begin
        if (rst) mcyc <= 64'd0;
        else     mcyc <= mcyc + 64'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One CSR instruction; captures the combinational read/illegal before the edge.
    task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        @(negedge clk);
        csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd;
        #1;
        rd_last = csr_rdata; ill_last = csr_illegal; mc_last = mcyc;
        @(posedge clk); #1;
        csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0;
    endtask

    task automatic csr_rd(input logic [11:0] a);
        csr_valid = 1'b1; csr_op = 2'b00; csr_addr = a; csr_wdata = '0;
        #1;
        rd_last = csr_rdata; ill_last = csr_illegal; mc_last = mcyc;
    endtask

    logic [11:0] addrs [17];

    initial begin
        addrs = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h040, 12'h041,
                  12'h042, 12'h043, 12'h044, 12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81,
                  12'hC82};
        rst = 1'b1;
        csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        trap_req = 0; uret_req = 0; inst_ret = 0;
        trap_pc = 0; trap_cause = 0; trap_val = 0;
        sw_irq = 0; timer_irq = 0; ext_irq = 0;
        c_inc = 0; c_wlo = 0; c_whi = 0; c_wd = 0;

        // Reset state, read while reset is held so counters stay at zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvec", trap_vector, 0);
        chk("rst_pend", irq_pending, 0);
        chk("rst_epc", epc, 0);
        for (int i = 0; i < 17; i++) begin
            csr_rd(addrs[i]);
            chk($sformatf("rst_rd_%h", addrs[i]), rd_last, 0);
            chk($sformatf("rst_ill_%h", addrs[i]), ill_last, 0);
        end
        csr_rd(12'h7C0);
        chk("unimpl_rd", rd_last, 0);
        chk("unimpl_ill", ill_last, 1);
        csr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Read-modify-write on uscratch.
        csr_do(2'b01, 12'h040, 32'hDEADBEEF);
        csr_rd(12'h040); chk("rw_scratch", rd_last, 32'hDEADBEEF);
        csr_do(2'b10, 12'h040, 32'h00000010);
        chk("rs_old", rd_last, 32'hDEADBEEF);
        csr_rd(12'h040); chk("rs_scratch", rd_last, 32'hDEADBEFF);
        csr_do(2'b11, 12'h040, 32'h0000000F);
        csr_rd(12'h040); chk("rc_scratch", rd_last, 32'hDEADBEF0);

        // Read-only counter space.
        csr_do(2'b01, 12'hC00, 32'h5);
        chk("rw_cycle_ill", ill_last, 1);
        csr_rd(12'hC00); chk("cycle_nowr", rd_last, mc_last[31:0]);
        csr_do(2'b10, 12'hC00, 32'h0);
        chk("rs0_cycle_ill", ill_last, 0);
        chk("rs0_cycle_val", rd_last, mc_last[31:0]);
        csr_rd(12'hC80); chk("cycleh", rd_last, 0);
        csr_rd(12'hC01); chk("time_div3", rd_last, mc_last[31:0] / 3);
        @(negedge clk); inst_ret = 1'b1;
        repeat (3) @(posedge clk);
        #1 inst_ret = 1'b0;
        csr_rd(12'hC02); chk("instret", rd_last, 3);

        // 64-bit counter half loads, carry and wrap.
        @(negedge clk); c_wlo = 1; c_wd = 32'hFFFFFFFF;
        @(negedge clk); c_wlo = 0; c_whi = 1; c_wd = 32'h12;
        @(negedge clk); c_whi = 0; c_inc = 1;
        @(negedge clk); c_inc = 0;
        chk("cnt_carry", c_cnt, 64'h00000013_00000000);
        c_wlo = 1; c_whi = 1; c_wd = 32'hFFFFFFFF;
        @(negedge clk); c_wlo = 0; c_whi = 0;
        chk("cnt_max", c_cnt, 64'hFFFFFFFF_FFFFFFFF);
        c_inc = 1;
        @(negedge clk); c_inc = 0;
        chk("cnt_wrap", c_cnt, 64'h0);

        // FP CSR aliasing.
        csr_do(2'b01, 12'h003, 32'hFFFFFFFF);
        csr_rd(12'h002); chk("frm_alias", rd_last, 32'h7);
        csr_rd(12'h001); chk("fflags_alias", rd_last, 32'h1F);
        csr_do(2'b01, 12'h002, 32'h2);
        csr_rd(12'h003); chk("fcsr_alias", rd_last, 32'h5F);

        // Trap entry with a colliding CSR write, then uret.
        csr_do(2'b01, 12'h005, 32'h00001003);
        csr_rd(12'h005); chk("utvec_bit1", rd_last, 32'h00001001);
        csr_do(2'b01, 12'h000, 32'h1);
        @(negedge clk);
        trap_req = 1; trap_pc = 32'h401; trap_cause = 32'h80000008; trap_val = 32'h1234;
        csr_valid = 1; csr_op = 2'b01; csr_addr = 12'h040; csr_wdata = 32'h55;
        #1 chk("tvec_vectored", trap_vector, 32'h00001020);
        @(posedge clk); #1;
        trap_req = 0; csr_valid = 0; csr_op = 0; csr_wdata = 0;
        trap_cause = 32'h2;
        #1 chk("tvec_exc", trap_vector, 32'h00001000);
        trap_cause = 32'h0;
        chk("epc", epc, 32'h400);
        csr_rd(12'h041); chk("uepc", rd_last, 32'h400);
        csr_rd(12'h042); chk("ucause", rd_last, 32'h80000008);
        csr_rd(12'h043); chk("utval", rd_last, 32'h1234);
        csr_rd(12'h000); chk("ustatus_trap", rd_last, 32'h10);
        csr_rd(12'h040); chk("scratch_dropped", rd_last, 32'hDEADBEF0);
        @(negedge clk); csr_valid = 0; uret_req = 1;
        @(posedge clk); #1 uret_req = 0;
        csr_rd(12'h000); chk("ustatus_uret", rd_last, 32'h11);

        // Interrupt generation and priority.
        csr_do(2'b01, 12'h004, 32'h100);
        @(negedge clk); ext_irq = 1;
        #1 chk("pend_ext", irq_pending, 1);
        chk("cause_ext", irq_cause, 32'h80000008);
        csr_do(2'b01, 12'h004, 32'h111);
        @(negedge clk); timer_irq = 1;
        #1 chk("cause_ext_tmr", irq_cause, 32'h80000008);
        ext_irq = 0;
        #1 chk("cause_tmr", irq_cause, 32'h80000004);
        sw_irq = 1;
        #1 chk("cause_sw", irq_cause, 32'h80000000);
        csr_rd(12'h044); chk("uip_rd", rd_last, 32'h11);
        csr_do(2'b11, 12'h000, 32'h1);
        #1 chk("pend_uie0", irq_pending, 0);
        csr_do(2'b10, 12'h000, 32'h1);
        #1 chk("pend_uie1", irq_pending, 1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("arst_pend", irq_pending, 0);
        chk("arst_epc", epc, 0);
        csr_rd(12'h040); chk("arst_scratch", rd_last, 0);
        csr_rd(12'hC00); chk("arst_cycle", rd_last, 0);
        csr_valid = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
